// File: rtl/kalman_pkg.sv
// -----------------------------------------------------------------------------
// kalman_pkg
// Shared definitions for the sequential Kalman measurement update:
//   - element/accumulator formats (signed Q20.12 elements, 72-bit accumulator)
//   - FSM state encoding
//   - round-half-up + saturate helper used at every element writeback
//   - flat-bus element index helper
// -----------------------------------------------------------------------------
package kalman_pkg;

  localparam int DW    = 32;
  localparam int FRAC  = 12;
  localparam int ACC_W = 72;

  // Half an LSB of the output format, expressed at accumulator scale.
  localparam logic signed [ACC_W-1:0] RND_HALF =
    {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_INNOV = 3'd2,
    ST_XUPD  = 3'd3,
    ST_HP    = 3'd4,
    ST_PUPD  = 3'd5,
    ST_FIN   = 3'd6
  } state_e;

  typedef struct packed {
    logic          ovf;
    logic [DW-1:0] val;
  } rs_t;

  // Round half up, drop FRAC bits, clamp to the signed DW range.
  function automatic rs_t round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shf;
    rs_t                     r;
    shf = (acc + RND_HALF) >>> FRAC;
    // The value fits when every bit above the DW sign bit equals the sign.
    if ((&shf[ACC_W-1:DW-1]) || (~|shf[ACC_W-1:DW-1])) begin
      r.ovf = 1'b0;
      r.val = shf[DW-1:0];
    end else if (shf[ACC_W-1]) begin
      r.ovf = 1'b1;
      r.val = {1'b1, {(DW-1){1'b0}}};
    end else begin
      r.ovf = 1'b1;
      r.val = {1'b0, {(DW-1){1'b1}}};
    end
    return r;
  endfunction

  // Element index of (row, col) in a row-major flat bus with the given stride.
  function automatic int flat_idx(input logic [2:0] row, input logic [2:0] col,
                                  input int stride);
    return int'(row) * stride + int'(col);
  endfunction

endpackage

// File: rtl/fxp_mac.sv
// -----------------------------------------------------------------------------
// fxp_mac
// Single multiply-accumulate unit shared by every phase of the update.
//   load_i        : acc <= (base_i <<< FRAC) +/- a_i*b_i  (first inner step)
//   acc_i         : acc <= acc +/- a_i*b_i                (later inner steps)
//   sub_i         : subtract the product instead of adding it
//   a_i, b_i      : signed DW operands, product kept at full 2*DW precision
//   base_i        : signed DW additive term
//   res_o / ovf_o : accumulator rounded to DW and its saturation flag
// -----------------------------------------------------------------------------
module fxp_mac
  import kalman_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          acc_i,
  input  logic          sub_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] base_i,
  output logic [DW-1:0] res_o,
  output logic          ovf_o
);

  logic signed [2*DW-1:0]  mul_s;
  logic signed [ACC_W-1:0] prod_s;
  logic signed [ACC_W-1:0] base_s;
  logic signed [ACC_W-1:0] src_s;
  logic signed [ACC_W-1:0] addend_s;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;
  rs_t                     rs_s;

  assign mul_s  = $signed({{DW{a_i[DW-1]}}, a_i}) * $signed({{DW{b_i[DW-1]}}, b_i});
  assign prod_s = {{(ACC_W-2*DW){mul_s[2*DW-1]}}, mul_s};
  assign base_s = {{(ACC_W-DW-FRAC){base_i[DW-1]}}, base_i, {FRAC{1'b0}}};

  // Next accumulator value: start from base on load, else from the running sum.
  always_comb begin
    if (load_i) begin
      src_s = base_s;
    end else begin
      src_s = acc_q;
    end
    if (sub_i) begin
      addend_s = -prod_s;
    end else begin
      addend_s = prod_s;
    end
    if (load_i || acc_i) begin
      acc_d = src_s + addend_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign rs_s  = round_sat(acc_q);
  assign res_o = rs_s.val;
  assign ovf_o = rs_s.ovf;

endmodule

// File: rtl/kalman_update_seq.sv
// -----------------------------------------------------------------------------
// kalman_update_seq
// Sequential Kalman measurement update with run-time sizes n<=NS_MAX, m<=NM_MAX:
//   x = xhat + K(z - H*xhat),  P = Phat - K(H*Phat)
// through one shared fxp_mac. Phases: INNOV (y), XUPD (x), HP (H*Phat), PUPD (P).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                request, only honoured in IDLE
//   n_state, n_meas      active dimensions, latched with start
//   sym_en               upper-triangle-and-mirror mode for P, latched with start
//   xhat/z/H/K/Phat_flat operand buses, must be stable while busy
//   x_update/P_update    result buses (registered)
//   busy, done, err, sat status (done is a one-cycle pulse)
// -----------------------------------------------------------------------------
module kalman_update_seq
  import kalman_pkg::*;
#(
  parameter int NS_MAX = 6,
  parameter int NM_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [2:0]                    n_state,
  input  logic [2:0]                    n_meas,
  input  logic                          sym_en,
  input  logic [NS_MAX*DW-1:0]          xhat_flat,
  input  logic [NM_MAX*DW-1:0]          z_flat,
  input  logic [NM_MAX*NS_MAX*DW-1:0]   H_flat,
  input  logic [NS_MAX*NM_MAX*DW-1:0]   K_flat,
  input  logic [NS_MAX*NS_MAX*DW-1:0]   Phat_flat,
  output logic [NS_MAX*DW-1:0]          x_update_flat,
  output logic [NS_MAX*NS_MAX*DW-1:0]   P_update_flat,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          sat
);

  localparam logic [2:0] NS_LIM = 3'(NS_MAX);
  localparam logic [2:0] NM_LIM = 3'(NM_MAX);

  state_e state_q, state_d;

  logic [2:0] n_q, m_q;
  logic       sym_q;
  logic [2:0] row_q, col_q, k_q;
  logic       wb_q;

  logic [NS_MAX*DW-1:0]        x_q;
  logic [NS_MAX*NS_MAX*DW-1:0] p_q;
  logic [NM_MAX*DW-1:0]        y_q;
  logic [NM_MAX*NS_MAX*DW-1:0] hp_q;
  logic busy_q, done_q, err_q, sat_q;

  logic [2:0]    inner_s, row_lim_s, col_lim_s;
  logic          last_k_s, last_col_s, last_row_s, elem_last_s, size_bad_s;
  logic          compute_s, chk_s, mac_load_s, mac_acc_s, wb_s;
  logic [DW-1:0] a_s, b_s, base_s, mac_res_s;
  logic          sub_s, mac_ovf_s;

  // Loop bounds of the current phase: inner length, row count, column count.
  always_comb begin
    inner_s   = 3'd1;
    row_lim_s = 3'd1;
    col_lim_s = 3'd1;
    case (state_q)
      ST_INNOV: begin inner_s = n_q; row_lim_s = m_q; end
      ST_XUPD:  begin inner_s = m_q; row_lim_s = n_q; end
      ST_HP:    begin inner_s = n_q; row_lim_s = m_q; col_lim_s = n_q; end
      ST_PUPD:  begin inner_s = m_q; row_lim_s = n_q; col_lim_s = n_q; end
      default:  begin inner_s = 3'd1; row_lim_s = 3'd1; col_lim_s = 3'd1; end
    endcase
  end

  assign last_k_s    = (k_q == inner_s - 3'd1);
  assign last_col_s  = (col_q == col_lim_s - 3'd1);
  assign last_row_s  = (row_q == row_lim_s - 3'd1);
  assign elem_last_s = last_row_s && last_col_s;
  assign size_bad_s  = (n_q == 3'd0) || (n_q > NS_LIM) || (m_q == 3'd0) || (m_q > NM_LIM);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; compute phases advance after the last element's writeback.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_CHECK : ST_IDLE;
      ST_CHECK: state_d = size_bad_s ? ST_FIN : ST_INNOV;
      ST_INNOV: state_d = (wb_q && elem_last_s) ? ST_XUPD : ST_INNOV;
      ST_XUPD:  state_d = (wb_q && elem_last_s) ? ST_HP : ST_XUPD;
      ST_HP:    state_d = (wb_q && elem_last_s) ? ST_PUPD : ST_HP;
      ST_PUPD:  state_d = (wb_q && elem_last_s) ? ST_FIN : ST_PUPD;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: phase strobes for the MAC and writeback.
  always_comb begin
    compute_s = 1'b0;
    chk_s     = 1'b0;
    case (state_q)
      ST_INNOV, ST_XUPD, ST_HP, ST_PUPD: compute_s = 1'b1;
      ST_CHECK:                          chk_s     = 1'b1;
      default:                           compute_s = 1'b0;
    endcase
    mac_load_s = compute_s && !wb_q && (k_q == 3'd0);
    mac_acc_s  = compute_s && !wb_q && (k_q != 3'd0);
    wb_s       = compute_s && wb_q;
  end

  // MAC operand selection for the current phase and indices.
  always_comb begin
    a_s    = '0;
    b_s    = '0;
    base_s = '0;
    sub_s  = 1'b0;
    case (state_q)
      ST_INNOV: begin
        a_s    = H_flat[flat_idx(row_q, k_q, NS_MAX)*DW +: DW];
        b_s    = xhat_flat[int'(k_q)*DW +: DW];
        base_s = z_flat[int'(row_q)*DW +: DW];
        sub_s  = 1'b1;
      end
      ST_XUPD: begin
        a_s    = K_flat[flat_idx(row_q, k_q, NM_MAX)*DW +: DW];
        b_s    = y_q[int'(k_q)*DW +: DW];
        base_s = xhat_flat[int'(row_q)*DW +: DW];
      end
      ST_HP: begin
        a_s    = H_flat[flat_idx(row_q, k_q, NS_MAX)*DW +: DW];
        b_s    = Phat_flat[flat_idx(k_q, col_q, NS_MAX)*DW +: DW];
      end
      ST_PUPD: begin
        a_s    = K_flat[flat_idx(row_q, k_q, NM_MAX)*DW +: DW];
        b_s    = hp_q[flat_idx(k_q, col_q, NS_MAX)*DW +: DW];
        base_s = Phat_flat[flat_idx(row_q, col_q, NS_MAX)*DW +: DW];
        sub_s  = 1'b1;
      end
      default: begin
        a_s = '0;
      end
    endcase
  end

  fxp_mac u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (mac_load_s),
    .acc_i  (mac_acc_s),
    .sub_i  (sub_s),
    .a_i    (a_s),
    .b_i    (b_s),
    .base_i (base_s),
    .res_o  (mac_res_s),
    .ovf_o  (mac_ovf_s)
  );

  // Element walk: inner steps, then a writeback step, then the next element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= 3'd0; col_q <= 3'd0; k_q <= 3'd0; wb_q <= 1'b0;
    end else if (!compute_s) begin
      row_q <= 3'd0; col_q <= 3'd0; k_q <= 3'd0; wb_q <= 1'b0;
    end else if (!wb_q) begin
      if (last_k_s) begin
        wb_q <= 1'b1;
      end else begin
        k_q <= k_q + 3'd1;
      end
    end else begin
      wb_q <= 1'b0;
      k_q  <= 3'd0;
      if (elem_last_s) begin
        row_q <= 3'd0;
        col_q <= 3'd0;
      end else if (last_col_s) begin
        row_q <= row_q + 3'd1;
        // Symmetric P rows start on the diagonal.
        col_q <= (state_q == ST_PUPD && sym_q) ? row_q + 3'd1 : 3'd0;
      end else begin
        col_q <= col_q + 3'd1;
      end
    end
  end

  // Result and intermediate storage: clear unused region on CHECK, write on writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      p_q  <= '0;
      y_q  <= '0;
      hp_q <= '0;
    end else if (chk_s && !size_bad_s) begin
      for (int i = 0; i < NS_MAX; i++) begin
        if (i >= int'(n_q)) x_q[i*DW +: DW] <= '0;
        for (int j = 0; j < NS_MAX; j++) begin
          if (i >= int'(n_q) || j >= int'(n_q)) p_q[(i*NS_MAX+j)*DW +: DW] <= '0;
        end
      end
    end else if (wb_s) begin
      case (state_q)
        ST_INNOV: y_q[int'(row_q)*DW +: DW] <= mac_res_s;
        ST_XUPD:  x_q[int'(row_q)*DW +: DW] <= mac_res_s;
        ST_HP:    hp_q[flat_idx(row_q, col_q, NS_MAX)*DW +: DW] <= mac_res_s;
        ST_PUPD: begin
          p_q[flat_idx(row_q, col_q, NS_MAX)*DW +: DW] <= mac_res_s;
          if (sym_q) p_q[flat_idx(col_q, row_q, NS_MAX)*DW +: DW] <= mac_res_s;
        end
        default: y_q <= y_q;
      endcase
    end
  end

  // Operation control and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 3'd0; m_q <= 3'd0; sym_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_FIN);
      if (state_q == ST_IDLE && start) begin
        n_q    <= n_state;
        m_q    <= n_meas;
        sym_q  <= sym_en;
        busy_q <= 1'b1;
        sat_q  <= 1'b0;
      end else if (state_q == ST_FIN) begin
        busy_q <= 1'b0;
      end else if (wb_s && mac_ovf_s) begin
        sat_q <= 1'b1;
      end
      if (chk_s) err_q <= size_bad_s;
    end
  end

  assign x_update_flat = x_q;
  assign P_update_flat = p_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign sat           = sat_q;

endmodule

// File: tb/tb_kalman_update_seq.sv
module tb_kalman_update_seq;

  localparam int NS   = 6;
  localparam int NM   = 4;
  localparam int DW   = 32;
  localparam int FRAC = 12;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n, start, sym_en;
  logic [2:0] n_state, n_meas;
  logic [NS*DW-1:0]    xhat_flat;
  logic [NM*DW-1:0]    z_flat;
  logic [NM*NS*DW-1:0] H_flat;
  logic [NS*NM*DW-1:0] K_flat;
  logic [NS*NS*DW-1:0] Phat_flat;
  logic [NS*DW-1:0]    x_update_flat;
  logic [NS*NS*DW-1:0] P_update_flat;
  logic busy, done, err, sat;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus matrices and expected results (plain integers, Q20.12 values).
  longint xh[NS], zz[NM], hh[NM][NS], kk[NS][NM], ph[NS][NS];
  longint ex[NS], ep[NS][NS];
  bit     e_sat, e_err;
  int     e_lat;

  always #5 clk = ~clk;

  kalman_update_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_state(n_state), .n_meas(n_meas),
    .sym_en(sym_en), .xhat_flat(xhat_flat), .z_flat(z_flat), .H_flat(H_flat),
    .K_flat(K_flat), .Phat_flat(Phat_flat), .x_update_flat(x_update_flat),
    .P_update_flat(P_update_flat), .busy(busy), .done(done), .err(err), .sat(sat)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint rv();
    return longint'($urandom_range(0, 65535)) - 64'sd32768;
  endfunction

  // Round half up to the element format and clamp, noting any clamp.
  task automatic rnd_sat(input longint acc, output longint v, inout bit s);
    v = (acc + (64'sd1 <<< (FRAC-1))) >>> FRAC;
    if (v > MAXV) begin v = MAXV; s = 1'b1; end
    else if (v < MINV) begin v = MINV; s = 1'b1; end
  endtask

  // Reference: the update equations evaluated element by element.
  task automatic model_op(input int n, input int m, input bit sym);
    longint y[NM];
    longint hp[NM][NS];
    longint acc, v;
    int     e;
    e_err = (n < 1 || n > NS || m < 1 || m > NM);
    e_sat = 1'b0;
    if (e_err) begin
      e_lat = 2;
      return;
    end
    for (int i = 0; i < NS; i++) begin
      if (i >= n) ex[i] = 0;
      for (int j = 0; j < NS; j++) if (i >= n || j >= n) ep[i][j] = 0;
    end
    for (int i = 0; i < m; i++) begin
      acc = zz[i] <<< FRAC;
      for (int j = 0; j < n; j++) acc -= hh[i][j] * xh[j];
      rnd_sat(acc, y[i], e_sat);
    end
    for (int i = 0; i < n; i++) begin
      acc = xh[i] <<< FRAC;
      for (int j = 0; j < m; j++) acc += kk[i][j] * y[j];
      rnd_sat(acc, ex[i], e_sat);
    end
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        acc = 0;
        for (int k = 0; k < n; k++) acc += hh[r][k] * ph[k][c];
        rnd_sat(acc, hp[r][c], e_sat);
      end
    for (int i = 0; i < n; i++)
      for (int c = 0; c < n; c++) begin
        if (sym && c < i) continue;
        acc = ph[i][c] <<< FRAC;
        for (int j = 0; j < m; j++) acc -= kk[i][j] * hp[j][c];
        rnd_sat(acc, v, e_sat);
        ep[i][c] = v;
        if (sym) ep[c][i] = v;
      end
    e = sym ? n*(n+1)/2 : n*n;
    e_lat = 2 + m*(n+1) + n*(m+1) + m*n*(n+1) + e*(m+1);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NS; i++) begin
      xhat_flat[i*DW +: DW] = xh[i][DW-1:0];
      for (int j = 0; j < NM; j++) K_flat[(i*NM+j)*DW +: DW] = kk[i][j][DW-1:0];
      for (int j = 0; j < NS; j++) Phat_flat[(i*NS+j)*DW +: DW] = ph[i][j][DW-1:0];
    end
    for (int i = 0; i < NM; i++) begin
      z_flat[i*DW +: DW] = zz[i][DW-1:0];
      for (int j = 0; j < NS; j++) H_flat[(i*NS+j)*DW +: DW] = hh[i][j][DW-1:0];
    end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < NS; i++) begin
      xh[i] = 0;
      for (int j = 0; j < NM; j++) kk[i][j] = 0;
      for (int j = 0; j < NS; j++) ph[i][j] = 0;
    end
    for (int i = 0; i < NM; i++) begin
      zz[i] = 0;
      for (int j = 0; j < NS; j++) hh[i][j] = 0;
    end
  endtask

  // Pulse start and count clock edges until done (bounded).
  task automatic run_op(input int n, input int m, input bit sym, output int cyc);
    @(negedge clk);
    n_state = 3'(n); n_meas = 3'(m); sym_en = sym; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < NS; i++) begin
      check_eq($sformatf("%s x[%0d]", tag, i), longint'($signed(x_update_flat[i*DW +: DW])), ex[i]);
      for (int j = 0; j < NS; j++)
        check_eq($sformatf("%s P[%0d][%0d]", tag, i, j),
                 longint'($signed(P_update_flat[(i*NS+j)*DW +: DW])), ep[i][j]);
    end
    check_eq({tag, " err"}, longint'(err), longint'(e_err));
    check_eq({tag, " sat"}, longint'(sat), longint'(e_sat));
    check_eq({tag, " busy"}, longint'(busy), 64'sd0);
  endtask

  task automatic run_and_check(input int n, input int m, input bit sym, input string tag);
    int cyc;
    drive_inputs();
    model_op(n, m, sym);
    run_op(n, m, sym, cyc);
    check_eq({tag, " latency"}, longint'(cyc), longint'(e_lat));
    compare_all(tag);
  endtask

  task automatic load_identity_case();
    clear_mats();
    for (int i = 0; i < NS; i++) begin
      xh[i] = 4096;
      ph[i][i] = 4096;
    end
    for (int i = 0; i < NM; i++) begin
      zz[i] = 12288;
      hh[i][i] = 4096;
      kk[i][i] = 2048;
    end
  endtask

  initial begin
    int cyc, nd, first, n, m;
    bit sym, saw_done;
    rst_n = 1'b0; start = 1'b0; sym_en = 1'b0; n_state = 3'd1; n_meas = 3'd1;
    clear_mats();
    drive_inputs();
    for (int i = 0; i < NS; i++) begin
      ex[i] = 0;
      for (int j = 0; j < NS; j++) ep[i][j] = 0;
    end
    e_sat = 1'b0; e_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    check_eq("reset done", longint'(done), 64'sd0);
    @(negedge clk) rst_n = 1'b1;

    // Scalar case.
    xh[0] = 4096; zz[0] = 8192; hh[0][0] = 4096; kk[0][0] = 2048; ph[0][0] = 4096;
    run_and_check(1, 1, 1'b0, "scalar");
    check_eq("scalar x const", longint'($signed(x_update_flat[DW-1:0])), 64'sd6144);
    check_eq("scalar P const", longint'($signed(P_update_flat[DW-1:0])), 64'sd2048);

    // Identity-structured 6x4, full and symmetric.
    load_identity_case();
    run_and_check(6, 4, 1'b0, "ident full");
    check_eq("ident x3 const", longint'($signed(x_update_flat[3*DW +: DW])), 64'sd8192);
    check_eq("ident x5 const", longint'($signed(x_update_flat[5*DW +: DW])), 64'sd4096);
    check_eq("ident P00 const", longint'($signed(P_update_flat[0 +: DW])), 64'sd2048);
    check_eq("ident P55 const", longint'($signed(P_update_flat[35*DW +: DW])), 64'sd4096);
    check_eq("ident lat const", longint'(e_lat), 64'sd408);
    run_and_check(6, 4, 1'b1, "ident sym");
    check_eq("ident sym lat const", longint'(e_lat), 64'sd333);

    // Randomized sizes, modes and operands.
    for (int t = 0; t < 16; t++) begin
      n = int'($urandom_range(1, NS));
      m = int'($urandom_range(1, NM));
      sym = (t < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      if (t < 3) begin n = NS; m = NM; end
      for (int i = 0; i < NS; i++) begin
        xh[i] = rv();
        for (int j = 0; j < NM; j++) kk[i][j] = rv();
        for (int j = 0; j < NS; j++) ph[i][j] = rv();
      end
      for (int i = 0; i < NM; i++) begin
        zz[i] = rv();
        for (int j = 0; j < NS; j++) hh[i][j] = rv();
      end
      if (sym) for (int i = 0; i < NS; i++) for (int j = 0; j < i; j++) ph[i][j] = ph[j][i];
      run_and_check(n, m, sym, $sformatf("rand%0d", t));
    end

    // Saturation, then a clean run clears the flag.
    clear_mats();
    xh[0] = 64'sh7FFF_F000; zz[0] = 64'sh7FFF_F000; kk[0][0] = 4096;
    run_and_check(1, 1, 1'b0, "sat");
    check_eq("sat x const", longint'($signed(x_update_flat[DW-1:0])), MAXV);
    check_eq("sat flag const", longint'(sat), 64'sd1);
    clear_mats();
    xh[0] = 4096; zz[0] = 8192; hh[0][0] = 4096; kk[0][0] = 2048; ph[0][0] = 4096;
    run_and_check(1, 1, 1'b0, "after sat");

    // Size errors leave outputs untouched.
    load_identity_case();
    run_and_check(7, 4, 1'b0, "err n7");
    run_and_check(3, 0, 1'b0, "err m0");

    // start pulsed while busy is ignored; exactly one done at the right cycle.
    load_identity_case();
    drive_inputs();
    model_op(2, 2, 1'b0);
    @(negedge clk);
    n_state = 3'd2; n_meas = 3'd2; sym_en = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nd = 0; first = 0;
    for (int c = 1; c <= e_lat + 20; c++) begin
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (first == 0) first = c;
      end
    end
    check_eq("busy-start done count", longint'(nd), 64'sd1);
    check_eq("busy-start latency", longint'(first), longint'(e_lat));
    compare_all("busy-start");

    // Reset in the middle of HP aborts with cleared outputs and no done.
    load_identity_case();
    drive_inputs();
    @(negedge clk);
    n_state = 3'd6; n_meas = 3'd4; sym_en = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (80) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    for (int i = 0; i < NS; i++) begin
      ex[i] = 0;
      for (int j = 0; j < NS; j++) ep[i][j] = 0;
    end
    e_sat = 1'b0; e_err = 1'b0;
    compare_all("mid reset");
    saw_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check_eq("mid reset no done", longint'(saw_done), 64'sd0);
    run_and_check(6, 4, 1'b0, "post reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kalman_update_seq.md
Name: kalman_update_seq

Overview:
Parametrised successor of the fixed 6x4 Kalman update. It computes the same two results:
- x = xhat + K(z − H·xhat)
- P = Phat − K(H·Phat)

Sizes are selectable at run time up to parameter maxima. All arithmetic runs through one time-multiplexed MAC with rounding and saturation. An optional symmetric-P mode computes only the upper triangle and mirrors it. The block sits after the gain stage in the filter pipeline; the predict stage feeds xhat and Phat.

Parameters:
NS_MAX, 6, maximum state dimension
NM_MAX, 4, maximum measurement dimension
DW, 32, element width, signed fixed point
FRAC, 12, fractional bits (Q20.12 at defaults)
ACC_W, 72, accumulator width, signed

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
n_state  in  3  active state dimension n, 1..NS_MAX
n_meas  in  3  active measurement dimension m, 1..NM_MAX
sym_en  in  1  symmetric-P mode, sampled with start
xhat_flat  in  NS_MAX*DW  predicted state
z_flat  in  NM_MAX*DW  measurement
H_flat  in  NM_MAX*NS_MAX*DW  H, row-major, row stride NS_MAX
K_flat  in  NS_MAX*NM_MAX*DW  K, row-major, row stride NM_MAX
Phat_flat  in  NS_MAX*NS_MAX*DW  predicted covariance, row stride NS_MAX
x_update_flat  out  NS_MAX*DW  updated state
P_update_flat  out  NS_MAX*NS_MAX*DW  updated covariance
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
err  out  1  size-error flag, valid with done
sat  out  1  sticky saturation flag for the last operation

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, internal y/HP storage 0, FSM to IDLE.
- Element (r,c) of a flat bus sits at bits [(r*stride+c)*DW +: DW].
- Inputs other than start, sizes and sym_en are not latched. They must stay stable while busy.

FSM: IDLE → CHECK → INNOV → XUPD → HP → PUPD → FIN → IDLE.
- IDLE: start=1 latches n, m, sym_en; busy←1; sat←0; go to CHECK. start is ignored when not in IDLE.
- CHECK (1 cycle):
  - If n or m is outside its valid range: err←1, outputs unchanged, go to FIN.
  - Else err←0; zero every x/P output element outside the active n/m region; go to INNOV.
- Element computation: each output element takes inner+1 cycles. Inner-length MAC cycles accumulate one product per cycle, then one writeback cycle.
- Writeback rounding: add 2^(FRAC−1), arithmetic shift right by FRAC. If the result exceeds the signed DW range, clamp to 0x7FFF_FFFF or 0x8000_0000 (at DW=32) and set sat.
- Accumulator: initialised with base<<<FRAC, where base is the additive term; products are added or subtracted at full 2*DW precision.
- INNOV: y[i] = z[i] − Σj H[i][j]·xhat[j]; i<m, inner n. y is stored internally (NM_MAX×DW).
- XUPD: x_update[i] = xhat[i] + Σj K[i][j]·y[j]; i<n, inner m.
- HP: HP[r][c] = Σk H[r][k]·Phat[k][c]; r<m, c<n, inner n. Stored internally (NM_MAX×NS_MAX×DW).
- PUPD: P[i][c] = Phat[i][c] − Σj K[i][j]·HP[j][c]; inner m.
  - sym_en=0: every i,c<n.
  - sym_en=1: only c≥i; the writeback also writes P[c][i].
- Element order is row-major; the inner index is ascending.
- FIN (1 cycle): done=1, busy←0, back to IDLE. x/P hold until the next successful writeback.
- Latency, start edge to done high:
  - L = 2 + m(n+1) + n(m+1) + mn(n+1) + E(m+1)
  - E = n² when sym_en=0; E = n(n+1)/2 when sym_en=1.
  - Error path: done 2 cycles after start.
- Reset mid-operation: abort immediately; no done pulse.
- start held high across FIN: a new operation starts on the following IDLE cycle (back-to-back allowed).

Decomposition:
- Package kalman_pkg: DW, FRAC, ACC_W defaults; FSM state encoding; rounding/saturation function; flat-index helper function.
- Sub-module fxp_mac: clear/load base, accumulate ±product, round+saturate output with overflow flag. The FSM, counters and storage stay in kalman_update_seq.

Test Plan:
1. Scalar case, n=1, m=1, sym_en=0. Inputs: xhat=4096, z=8192, H=4096, K=2048, Phat=4096. Expect: x=6144, P=2048, done at L=10, err=0, sat=0.
2. n=6, m=4. Inputs: H=[I4|0], K=0.5·[I4;0], xhat all 4096, z all 12288, Phat=I6. Expect:
   - x = 8192 ×4, then 4096 ×2.
   - P diagonal = 2048 ×4, then 4096 ×2; off-diagonal 0.
   - sym_en=0: done at L=408. sym_en=1: done at L=333, with identical P.
3. Random symmetric Phat, sym_en=1, versus a golden model → P exactly symmetric, and every element matches the model (including round-half-up on negative products).
4. n=1, m=1. Inputs: xhat=0x7FFF_F000, K=4096, z=0x7FFF_F000, H=0, Phat=0. Expect: x=0x7FFF_FFFF, sat=1. A following normal run clears sat.
5. n_state=7 → done 2 cycles after start, err=1, outputs unchanged. Then n_meas=0 → same result.
6. start pulsed while busy → ignored, single done. rst_n low mid-HP → all outputs 0 and no done. Next start runs to the correct result.
